// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  // FSM state encodings
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Width of one BCD digit
  localparam int BCD_W = 4;

  // Counter width able to hold WIDTH itself
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake and result bus of the BCD converter.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   blank;
  logic                ovf;

  modport master (output start, bin, input busy, done, bcd, blank, ovf);
  modport slave  (input start, bin, output busy, done, bcd, blank, ovf);
endinterface

// File: rtl/bin2bcd_seq_bcd_add3.sv
// One-digit shift-and-add-3 correction: d >= 5 ? d+3 : d.
// Corrected values 8..12 still fit in 4 bits, so no widening.
module bcd_add3 (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);
  assign o_d = (i_d >= 4'd5) ? (i_d + 4'd3) : i_d;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock. Results are held
// stable between conversions so the downstream 7-segment decoders never
// see intermediate values.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          clrn,
  bin2bcd_seq_if.slave  bus
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam int SCR_W = BCD_W * DIGITS;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [SCR_W-1:0] r_scr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sticky;
  logic             r_busy;
  logic             r_done;
  logic [SCR_W-1:0] r_bcd;
  logic [DIGITS-1:0] r_blank;
  logic             r_ovf;

  logic [SCR_W-1:0]       w_adj;
  logic [SCR_W+WIDTH-1:0] w_cat_sh;
  logic [SCR_W-1:0]       w_scr_nxt;
  logic [WIDTH-1:0]       w_sreg_nxt;
  logic                   w_out;
  logic                   w_last;
  logic [DIGITS-1:0]      w_blank;

  // Per-digit correction, all digits in parallel
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_add3 u_add3 (
      .i_d (r_scr[BCD_W*g +: BCD_W]),
      .o_d (w_adj[BCD_W*g +: BCD_W])
    );
  end

  // Shift corrected {scratch, shift reg} left by one; top bit falls out
  assign w_cat_sh   = {w_adj, r_sreg} << 1;
  assign w_scr_nxt  = w_cat_sh[SCR_W+WIDTH-1:WIDTH];
  assign w_sreg_nxt = w_cat_sh[WIDTH-1:0];
  assign w_out      = w_adj[SCR_W-1];
  assign w_last     = (r_cnt == CNT_W'(1));

  // Leading-zero mask from the digits about to be stored; digit 0 never blanks
  always_comb begin
    logic v_run;
    w_blank = '0;
    v_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      v_run      = v_run & (w_scr_nxt[BCD_W*i +: BCD_W] == '0);
      w_blank[i] = v_run;
    end
  end

  // FSM, datapath and output registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state  <= ST_IDLE;
      r_sreg   <= '0;
      r_scr    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bcd    <= '0;
      r_blank  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_sreg   <= bus.bin;
            r_scr    <= '0;
            r_cnt    <= CNT_W'(WIDTH);
            r_sticky <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= ST_SHIFT;
          end
        end
        default: begin
          r_sreg   <= w_sreg_nxt;
          r_scr    <= w_scr_nxt;
          r_sticky <= r_sticky | w_out;
          r_cnt    <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_bcd   <= w_scr_nxt;
            r_ovf   <= r_sticky | w_out;
            r_blank <= w_blank;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.bcd   = r_bcd;
  assign bus.blank = r_blank;
  assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq: an 8-bit and a 10-bit
// instance, both 3 digits, checked against a decimal reference model.
module tb_bin2bcd_seq;

  logic clk;
  logic clrn;
  int   n_tot;
  int   n_bad;

  bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) b8  ();
  bin2bcd_seq_if #(.WIDTH(10), .DIGITS(3)) b10 ();

  bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) u_dut8  (.clk(clk), .clrn(clrn), .bus(b8));
  bin2bcd_seq #(.WIDTH(10), .DIGITS(3)) u_dut10 (.clk(clk), .clrn(clrn), .bus(b10));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Decimal reference: low three digits, overflow, leading-zero mask
  task automatic model(input int v, output logic [11:0] bcd, output logic [2:0] blank,
                       output logic ovf);
    int t;
    t     = v % 1000;
    bcd   = {4'(t / 100), 4'((t / 10) % 10), 4'(t % 10)};
    ovf   = (v >= 1000);
    blank = {t < 100, t < 10, 1'b0};
  endtask

  task automatic drive(input bit sel, input bit st, input int v);
    if (sel) begin b10.start = st; b10.bin = 10'(v); end
    else     begin b8.start  = st; b8.bin  = 8'(v);  end
  endtask

  function automatic logic g_busy(input bit s);  return s ? b10.busy  : b8.busy;  endfunction
  function automatic logic g_done(input bit s);  return s ? b10.done  : b8.done;  endfunction
  function automatic logic [11:0] g_bcd(input bit s); return s ? b10.bcd : b8.bcd; endfunction
  function automatic logic [2:0] g_blank(input bit s); return s ? b10.blank : b8.blank; endfunction
  function automatic logic g_ovf(input bit s);   return s ? b10.ovf   : b8.ovf;   endfunction

  // One conversion starting at a negedge. inj: pulse start with a different
  // operand mid-conversion. rst_at>0: drop clrn at that cycle instead.
  task automatic conv(input bit sel, input int v, input bit inj, input int rst_at);
    logic [11:0] eb;
    logic [2:0]  ebl;
    logic        eo;
    int          k;
    bit          seen;
    model(v, eb, ebl, eo);
    drive(sel, 1'b1, v);
    seen = 0;
    k    = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        drive(sel, 1'b0, v);
        chk("busy_after_start", 32'(g_busy(sel)), 1);
        chk("done_low_at_start", 32'(g_done(sel)), 0);
      end
      if (inj && k == 3) drive(sel, 1'b1, v ^ 'h2A5);
      if (inj && k == 4) drive(sel, 1'b0, v);
      if (rst_at == k) begin
        clrn = 1'b0;
        #1;
        chk("rst_busy",  32'(g_busy(sel)),  0);
        chk("rst_done",  32'(g_done(sel)),  0);
        chk("rst_bcd",   32'(g_bcd(sel)),   0);
        chk("rst_blank", 32'(g_blank(sel)), 0);
        chk("rst_ovf",   32'(g_ovf(sel)),   0);
        @(negedge clk);
        clrn = 1'b1;
        for (int j = 0; j < 15; j++) begin
          @(negedge clk);
          chk("no_done_after_rst", 32'(g_done(sel)), 0);
        end
        return;
      end
      if (g_done(sel)) begin
        seen = 1;
        chk("latency", 32'(k - 1), sel ? 10 : 8);
        chk("done_not_busy", 32'(g_busy(sel)), 0);
        chk("bcd",   32'(g_bcd(sel)),   32'(eb));
        chk("blank", 32'(g_blank(sel)), 32'(ebl));
        chk("ovf",   32'(g_ovf(sel)),   32'(eo));
      end else if (k > 1) begin
        chk("busy_during", 32'(g_busy(sel)), 1);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    if (inj) begin
      for (int j = 0; j < 12; j++) begin
        @(negedge clk);
        chk("single_done", 32'(g_done(sel)), 0);
        chk("bcd_held", 32'(g_bcd(sel)), 32'(eb));
      end
    end
  endtask

  initial begin
    n_tot = 0;
    n_bad = 0;
    clrn  = 1'b0;
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);

    // Reset with random inputs toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0, 1'($urandom), int'($urandom));
      drive(1, 1'($urandom), int'($urandom));
    end
    #1;
    chk("reset_busy",  32'(b8.busy),  0);
    chk("reset_done",  32'(b8.done),  0);
    chk("reset_bcd",   32'(b8.bcd),   0);
    chk("reset_blank", 32'(b8.blank), 0);
    chk("reset_ovf",   32'(b8.ovf),   0);
    chk("reset_busy10", 32'(b10.busy), 0);
    @(negedge clk);
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    clrn = 1'b1;
    @(negedge clk);

    // Directed values, back-to-back starts in the done cycle
    conv(0, 255, 0, 0);
    conv(0, 0,   0, 0);
    conv(0, 9,   0, 0);
    conv(0, 100, 0, 0);

    // Start mid-conversion ignored; then reset mid-conversion
    conv(0, 77,  1, 0);
    conv(0, 255, 0, 0);
    conv(0, 200, 0, 4);
    @(negedge clk);

    // 10-bit instance boundaries and random operands
    conv(1, 999,  0, 0);
    conv(1, 1000, 0, 0);
    conv(1, 1023, 0, 0);
    for (int i = 0; i < 20; i++) conv(1, int'($urandom_range(0, 1023)), 0, 0);
    conv(1, 523, 1, 0);

    // Exhaustive 8-bit sweep plus random repeats
    for (int v = 0; v < 256; v++) conv(0, v, 0, 0);
    for (int i = 0; i < 20; i++) conv(0, int'($urandom_range(0, 255)), 0, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
